// File: rtl/branch_stall_ctrl.sv
// rtl/branch_stall_ctrl.sv - branch hazard stall/bubble/flush sequencer for blt/bne in decode
//
// Optional feature macro: BRANCH_FWD_EN (operand forwarding from X/M instead of stalling)
//
// Parameters:
//   STALL_CYCLES  cycles the branch is held in decode after a hazard (1..7)
//   CNT_W         width of the saturating stall statistics counter
//
// Ports:
//   clock        pipeline clock, rising edge
//   reset_n      asynchronous active-low reset
//   b_now        blt/bne currently in decode
//   hz_pass      detector pass: branch operand written by older ALU/addi
//   hz_rs        detector prob_rs: rs operand conflicts
//   hz_rd        detector prob_rd: rd operand conflicts
//   br_taken     branch compare result from decode, valid when b_now
//   stall_pc     hold PC
//   stall_fd     hold F/D latch
//   bubble_dx    load nop into D/X latch
//   flush_fd     replace F/D contents with nop
//   fwd_rs       select X/M result for branch rs operand
//   fwd_rd       select X/M result for branch rd operand
//   busy         FSM not in IDLE
//   stall_count  total stall cycles since reset, saturating

module branch_stall_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             b_now,
  input  logic             hz_pass,
  input  logic             hz_rs,
  input  logic             hz_rd,
  input  logic             br_taken,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             bubble_dx,
  output logic             flush_fd,
  output logic             fwd_rs,
  output logic             fwd_rd,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       rs_q;
  logic       rd_q;
  logic       hazard;
  logic       stall_now;
  logic       unused_flags;

  // Latched operand-conflict flags are kept for debug visibility only.
  assign unused_flags = rs_q ^ rd_q;

  assign hazard = (state == IDLE) & b_now & hz_pass;

  // The IDLE hazard cycle must stall immediately, so the stall term is
  // partly combinational; gating with reset_n keeps every output low while
  // reset is held even if the detector is still asserting.
  always_comb begin
    stall_now = 1'b0;
    fwd_rs    = 1'b0;
    fwd_rd    = 1'b0;
`ifdef BRANCH_FWD_EN
    if (reset_n && hazard) begin
      fwd_rs = hz_rs;
      fwd_rd = hz_rd;
    end
`else
    stall_now = reset_n & (hazard | (state == STALL));
`endif
  end

  assign stall_pc  = stall_now;
  assign stall_fd  = stall_now;
  assign bubble_dx = stall_now;
  assign flush_fd  = (state == FLUSH);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      rs_q        <= 1'b0;
      rd_q        <= 1'b0;
      stall_count <= '0;
    end else begin
      if (stall_now && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);

      case (state)
        IDLE: begin
          if (b_now) begin
`ifdef BRANCH_FWD_EN
            // Forwarded operands make br_taken trustworthy this cycle.
            if (br_taken)
              state <= FLUSH;
`else
            // Hazard wins over br_taken: the compare used stale operands.
            if (hz_pass) begin
              state <= STALL;
              cnt   <= 3'(STALL_CYCLES - 1);
              rs_q  <= hz_rs;
              rd_q  <= hz_rd;
            end else if (br_taken) begin
              state <= FLUSH;
            end
`endif
          end
        end
        STALL: begin
          if (cnt == 3'd0)
            state <= RESOLVE;
          else
            cnt <= cnt - 3'd1;
        end
        RESOLVE: state <= br_taken ? FLUSH : IDLE;
        // The flushed slot is not a real branch, so b_now is ignored here.
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// tb/tb_branch_stall_ctrl.sv - scoreboard bench for branch_stall_ctrl

module tb_branch_stall_ctrl;

  logic clock;
  logic reset_n;
  logic b_now_a, b_now_b;
  logic hz_pass, hz_rs, hz_rd, br_taken;

  logic        stall_pc_a, stall_fd_a, bubble_dx_a, flush_fd_a, fwd_rs_a, fwd_rd_a, busy_a;
  logic [15:0] stall_count_a;
  logic        stall_pc_b, stall_fd_b, bubble_dx_b, flush_fd_b, fwd_rs_b, fwd_rd_b, busy_b;
  logic [1:0]  stall_count_b;

  branch_stall_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .b_now(b_now_a), .hz_pass(hz_pass),
    .hz_rs(hz_rs), .hz_rd(hz_rd), .br_taken(br_taken),
    .stall_pc(stall_pc_a), .stall_fd(stall_fd_a), .bubble_dx(bubble_dx_a),
    .flush_fd(flush_fd_a), .fwd_rs(fwd_rs_a), .fwd_rd(fwd_rd_a),
    .busy(busy_a), .stall_count(stall_count_a)
  );

  branch_stall_ctrl #(.STALL_CYCLES(3), .CNT_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .b_now(b_now_b), .hz_pass(hz_pass),
    .hz_rs(hz_rs), .hz_rd(hz_rd), .br_taken(br_taken),
    .stall_pc(stall_pc_b), .stall_fd(stall_fd_b), .bubble_dx(bubble_dx_b),
    .flush_fd(flush_fd_b), .fwd_rs(fwd_rs_b), .fwd_rd(fwd_rd_b),
    .busy(busy_b), .stall_count(stall_count_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit          sel;
    logic [6:0]  vec;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  event async_chk;

  // Monitor: pops one expectation per negedge, or on an async-reset probe.
  initial begin
    exp_t        e;
    logic [6:0]  act_v;
    logic [15:0] act_c;
    forever begin
      @(negedge clock or async_chk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel) begin
          act_v = {stall_pc_b, stall_fd_b, bubble_dx_b, flush_fd_b, fwd_rs_b, fwd_rd_b, busy_b};
          act_c = {14'd0, stall_count_b};
        end else begin
          act_v = {stall_pc_a, stall_fd_a, bubble_dx_a, flush_fd_a, fwd_rs_a, fwd_rd_a, busy_a};
          act_c = stall_count_a;
        end
        tests++;
        if (act_v !== e.vec) begin
          fails++;
          $display("FAIL %s outputs{pc,fd,dx,flush,fwd_rs,fwd_rd,busy} act=%b exp=%b", e.name, act_v, e.vec);
        end
        tests++;
        if (act_c !== e.cnt) begin
          fails++;
          $display("FAIL %s stall_count act=%0d exp=%0d", e.name, act_c, e.cnt);
        end
      end
    end
  end

  function automatic exp_t mk(input bit sel, input logic pc, input logic fl,
                              input logic bz, input int sc, input string nm);
    exp_t e;
    e.sel  = sel;
    e.vec  = {pc, pc, pc, fl, 1'b0, 1'b0, bz};
    e.cnt  = 16'(sc);
    e.name = nm;
    return e;
  endfunction

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input bit sel, input logic rst, input logic bn, input logic ps,
                      input logic rs, input logic rd, input logic tk,
                      input logic pc, input logic fl, input logic bz,
                      input int sc, input string nm);
    @(posedge clock);
    #1;
    reset_n  = rst;
    b_now_a  = sel ? 1'b0 : bn;
    b_now_b  = sel ? bn : 1'b0;
    hz_pass  = ps;
    hz_rs    = rs;
    hz_rd    = rd;
    br_taken = tk;
    q.push_back(mk(sel, pc, fl, bz, sc, nm));
  endtask

  initial begin
    reset_n = 1'b0; b_now_a = 0; b_now_b = 0;
    hz_pass = 0; hz_rs = 0; hz_rd = 0; br_taken = 0;

    // reset held 3 cycles, then release
    step(0,0, 0,0,0,0,0, 0,0,0,0, "rst_hold0");
    step(0,0, 0,0,0,0,0, 0,0,0,0, "rst_hold1");
    step(0,0, 0,0,0,0,0, 0,0,0,0, "rst_hold2");
    step(0,1, 0,0,0,0,0, 0,0,0,0, "rst_release");

    // hazard, not taken
    step(0,1, 1,1,1,0,0, 1,0,0,0, "s2_idle_hz");
    step(0,1, 0,0,0,0,0, 1,0,1,1, "s2_stall");
    step(0,1, 0,0,0,0,0, 0,0,1,2, "s2_resolve_nt");
    step(0,1, 0,0,0,0,0, 0,0,0,2, "s2_idle");

    // hazard, taken on resolve
    step(0,1, 1,1,1,0,0, 1,0,0,2, "s3_idle_hz");
    step(0,1, 0,0,0,0,0, 1,0,1,3, "s3_stall");
    step(0,1, 0,0,0,0,1, 0,0,1,4, "s3_resolve_tk");
    step(0,1, 0,0,0,0,0, 0,1,1,4, "s3_flush");
    step(0,1, 0,0,0,0,0, 0,0,0,4, "s3_idle");

    // no hazard, taken
    step(0,1, 1,0,0,0,1, 0,0,0,4, "s4_idle_tk");
    step(0,1, 0,0,0,0,0, 0,1,1,4, "s4_flush");
    step(0,1, 0,0,0,0,0, 0,0,0,4, "s4_idle");

    // hazard and taken together: hazard wins
    step(0,1, 1,1,0,1,1, 1,0,0,4, "s5_hz_and_tk");
    step(0,1, 0,0,0,0,1, 1,0,1,5, "s5_stall");
    step(0,1, 0,0,0,0,0, 0,0,1,6, "s5_resolve_nt");
    step(0,1, 0,0,0,0,0, 0,0,0,6, "s5_idle");

    // new branch during FLUSH is ignored
    step(0,1, 1,0,0,0,1, 0,0,0,6, "s5b_idle_tk");
    step(0,1, 1,1,1,1,1, 0,1,1,6, "s5b_flush_bnow");
    step(0,1, 0,0,0,0,0, 0,0,0,6, "s5b_idle");

    // hz_pass without b_now is ignored
    step(0,1, 0,1,1,1,1, 0,0,0,6, "pass_no_bnow");

    // reset in the middle of STALL
    step(0,1, 1,1,0,0,0, 1,0,0,6, "r_idle_hz");
    step(0,1, 0,0,0,0,0, 1,0,1,7, "r_stall");
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    q.push_back(mk(0, 0, 0, 0, 0, "r_async_drop"));
    -> async_chk;
    step(0,0, 0,0,0,0,0, 0,0,0,0, "r_hold");
    step(0,1, 0,0,0,0,0, 0,0,0,0, "r_release");

    // STALL_CYCLES=3, CNT_W=2: two hazards, counter saturates at 3
    step(1,1, 1,1,1,0,0, 1,0,0,0, "s6a_idle_hz");
    step(1,1, 0,0,0,0,0, 1,0,1,1, "s6a_stall0");
    step(1,1, 0,0,0,0,0, 1,0,1,2, "s6a_stall1");
    step(1,1, 0,0,0,0,0, 1,0,1,3, "s6a_stall2");
    step(1,1, 0,0,0,0,0, 0,0,1,3, "s6a_resolve");
    step(1,1, 0,0,0,0,0, 0,0,0,3, "s6a_idle");
    step(1,1, 1,1,0,1,0, 1,0,0,3, "s6b_idle_hz");
    step(1,1, 0,0,0,0,0, 1,0,1,3, "s6b_stall0");
    step(1,1, 0,0,0,0,0, 1,0,1,3, "s6b_stall1");
    step(1,1, 0,0,0,0,0, 1,0,1,3, "s6b_stall2");
    step(1,1, 0,0,0,0,0, 0,0,1,3, "s6b_resolve");
    step(1,1, 0,0,0,0,0, 0,0,0,3, "s6b_idle");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clock);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain scoreboard left=%0d exp=0", q.size());
      $fatal(1, "scoreboard not drained");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_stall_ctrl.md
Name: branch_stall_ctrl

Overview:
Sequencing partner of the decode-stage branch hazard detector for blt/bne. It consumes the detector's pass/prob_rs/prob_rd flags and the branch outcome. It then drives PC/F-D stall, D-X bubble insertion and F-D flush. It sits in the hazard unit between the decode stage and the pipeline latch enables.

Parameters:
STALL_CYCLES, 1, cycles the branch is held in decode after a hazard; legal range 1..7
CNT_W, 16, width of the saturating stall statistics counter

Ports:
clock  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
b_now  input  1  blt/bne currently in decode
hz_pass  input  1  detector pass: branch operand written by the older ALU/addi instruction
hz_rs  input  1  detector prob_rs: rs operand conflicts
hz_rd  input  1  detector prob_rd: rd operand conflicts
br_taken  input  1  branch compare result from decode, valid when b_now
stall_pc  output  1  hold PC
stall_fd  output  1  hold F/D latch
bubble_dx  output  1  load nop into D/X latch
flush_fd  output  1  replace F/D contents with nop
fwd_rs  output  1  select X/M result for branch rs operand (see optional feature)
fwd_rd  output  1  select X/M result for branch rd operand (see optional feature)
busy  output  1  FSM not in IDLE
stall_count  output  CNT_W  total stall cycles since reset, saturating

Behaviour:
- States: IDLE, STALL, RESOLVE, FLUSH. 2-bit encoding. 3-bit down-counter cnt.
- Reset (async, reset_n=0): state=IDLE, cnt=0, latched rs/rd flags=0, stall_count=0. All outputs 0. Reset mid-STALL or mid-FLUSH aborts immediately with no residual stall.
- IDLE, hazard condition is b_now & hz_pass:
  - stall_pc, stall_fd and bubble_dx are asserted combinationally in the same cycle.
  - Next state=STALL. cnt<=STALL_CYCLES-1. Latch hz_rs and hz_rd.
- IDLE, b_now & ~hz_pass & br_taken: no stall; next state=FLUSH.
- IDLE, b_now & ~hz_pass & ~br_taken: remain in IDLE; outputs 0.
- IDLE, simultaneous hz_pass and br_taken: the hazard wins. br_taken is ignored because the operands are stale.
- IDLE, hz_pass with b_now=0: ignored.
- STALL:
  - stall_pc=stall_fd=bubble_dx=1, registered.
  - If cnt==0, next state=RESOLVE; else cnt<=cnt-1.
  - hz_pass, hz_rs and hz_rd are ignored in this state.
- RESOLVE:
  - All stall outputs 0; the branch re-evaluates with valid operands.
  - br_taken=1: next state=FLUSH. br_taken=0: next state=IDLE.
  - The pass flag is not re-checked here.
- FLUSH: flush_fd=1 for exactly one cycle; next state=IDLE. A new b_now in this cycle is ignored, because the flushed instruction is not a real branch.
- Latency:
  - Hazard branch: 1 (IDLE) + STALL_CYCLES + 1 (RESOLVE) cycles in decode.
  - Taken branch adds one flush cycle.
- stall_count: +1 on every cycle stall_pc=1 (including the combinational IDLE cycle). Saturates at all-ones and does not wrap.
- busy=1 in STALL, RESOLVE and FLUSH.

Optional Feature:
- Macro BRANCH_FWD_EN.
- Defined:
  - A hazard in IDLE does not stall. fwd_rs=hz_rs and fwd_rd=hz_rd are asserted combinationally in that cycle.
  - br_taken is treated as valid that cycle: taken -> FLUSH, not taken -> remain in IDLE.
  - STALL and RESOLVE are unreachable. stall_count stays 0.
- Undefined: fwd_rs=fwd_rd=0 constant; stall behaviour as above.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles, then release -> all outputs 0, busy=0, stall_count=0. Assert reset_n=0 while in STALL -> outputs drop to 0 without waiting for a clock edge.
2. STALL_CYCLES=1; b_now=1, hz_pass=1, hz_rs=1, br_taken=0 for 1 cycle.
   - Required: stall_pc=1 for 2 cycles (IDLE and STALL), then RESOLVE; br_taken=0 -> IDLE.
   - Required: flush_fd never asserted; stall_count=2.
3. Same stimulus as 2, with br_taken=1 in RESOLVE -> flush_fd=1 for exactly one cycle after RESOLVE, then busy=0.
4. No hazard: b_now=1, hz_pass=0, br_taken=1 -> no stall; flush_fd=1 in the next cycle; stall_count unchanged.
5. Simultaneous events:
   - hz_pass=1 and br_taken=1 in the same IDLE cycle -> STALL entered, no immediate flush.
   - b_now=1 pulsed during FLUSH -> ignored.
6. STALL_CYCLES=3 with CNT_W=2:
   - Two hazard branches -> stall_count saturates at 3.
   - Each hazard branch asserts stall_pc for 4 cycles.
   - With BRANCH_FWD_EN defined, scenario 2 instead gives fwd_rs=1 for 1 cycle, stall_pc never asserted and stall_count=0.
